alu_seq_arb: RTL and testbench
==============================

ALU_SEQ_ARB -- requirements
Module: alu_seq_arb

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  requester 0/1 holds an operation pending
- a0 / a1  in  8  operand A of requester 0/1
- b0 / b1  in  8  operand B of requester 0/1
- sub0 / sub1  in  1  1 = A-B, 0 = A+B
- ack0 / ack1  out  1  one-cycle pulse: operands captured
- sl_a  out  2  A digit to the shared 2-bit adder slice
- sl_b  out  2  B digit to the slice, already inverted for subtract
- sl_ci  out  1  slice carry-in
- sl_sum  in  2  slice sum, combinational from sl_a/sl_b/sl_ci
- sl_co  in  1  slice carry-out, combinational
- rsp_v  out  1  result valid
- rsp_id  out  1  requester served
- rsp_r  out  8  result
- rsp_co  out  1  final carry; for subtract 1 = no borrow (A>=B)
- rsp_rdy  in  1  consumer accepts result
- busy  out  1  state != IDLE

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE.
REQ-004 IDLE with req0 or req1 high:
- grant one requester, latch its a, b and sub
- pulse its ack for exactly that cycle
- clear the digit counter to 0
- go to RUN
REQ-005 Arbitration SHALL be round-robin:
- a sole requester is always granted
- on simultaneous requests, grant the one not served last
- after reset, requester 0 has priority
REQ-006 RUN SHALL take exactly 4 cycles, digit k = 0..3, LSB digit first:
- sl_a = A[2k+1:2k]
- sl_b = B[2k+1:2k], XOR sub replicated
- sl_ci = sub when k = 0, else the carry register
- each cycle, register sl_sum into result bits [2k+1:2k] and sl_co into the carry register
REQ-007 After digit 3 the block SHALL enter DONE with rsp_v=1, rsp_r = 8-bit result and rsp_co = final carry.
REQ-008 Result arithmetic SHALL be modulo 256.
- add: {rsp_co,rsp_r} = A+B
- subtract: rsp_r = A-B mod 256, rsp_co = (A>=B)
REQ-009 Latency SHALL be 5 cycles from ack to the first cycle of rsp_v.
REQ-010 rsp_v, rsp_id, rsp_r and rsp_co SHALL hold stable in DONE until the cycle rsp_rdy=1. On that edge the FSM returns to IDLE.
REQ-011 A new grant SHALL NOT occur in the cycle a result is accepted; the earliest next ack is the following cycle.
REQ-012 Request lines and operand changes SHALL be ignored outside IDLE; operands are sampled only in the ack cycle.
REQ-013 sl_a, sl_b and sl_ci SHALL be 0 outside RUN.
REQ-014 Only one operation SHALL be in flight; there is no queueing.

Reset
REQ-015 While rst_n=0:
- state = IDLE, digit counter = 0, carry and result registers = 0
- round-robin pointer favours requester 0
- ack0, ack1, rsp_v, rsp_id, rsp_r, rsp_co, busy and sl_* = 0
REQ-016 Reset asserted during RUN or DONE SHALL abort the operation with no response. The requester must re-request.

Verification
REQ-017 req0, a0=0x5A, b0=0x3C, sub0=0 -> ack0 one cycle; 5 cycles later rsp_v=1, rsp_id=0, rsp_r=0x96, rsp_co=0.
REQ-018 req1, a1=0x00, b1=0x01, sub1=1 -> rsp_r=0xFF, rsp_co=0. With a1=0x10, b1=0x01 -> rsp_r=0x0F, rsp_co=1.
REQ-019 req0 and req1 held high continuously, rsp_rdy=1 -> grants alternate 0,1,0,1; ack pulses are 6 cycles apart; rsp_id matches each grant.
REQ-020 Operation 0xFF+0x01 with rsp_rdy=0 for 10 cycles -> rsp_v and rsp_r=0x00, rsp_co=1 hold stable for all 10 cycles; no ack during the hold; IDLE the cycle after rsp_rdy=1.
REQ-021 Reset pulsed in the 2nd RUN cycle -> all outputs 0 immediately; no rsp_v. Next req1 alone is granted normally and the result is correct.
REQ-022 Change a0/b0 during RUN -> result still reflects the operands captured at ack.

Source files
------------

// File: rtl/alu_seq_arb.sv
// alu_seq_arb: two-requester round-robin front end for an 8-bit add/subtract
// that is computed serially, one 2-bit digit per cycle, on an external
// combinational 2-bit adder slice.
//
// State table
//   IDLE | waiting for a request; grants, pulses ack and latches operands
//   RUN  | four digit cycles, LSB digit first, through the shared slice
//   DONE | result presented on rsp_*; held until rsp_rdy
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req0/1, a0/1, b0/1,     requester handshakes and operands
//   sub0/1, ack0/1
//   sl_a, sl_b, sl_ci       digit operands to the slice (B pre-inverted on sub)
//   sl_sum, sl_co           slice result, combinational
//   rsp_v, rsp_id, rsp_r,   response; rsp_co is the carry, which for a
//   rsp_co, rsp_rdy         subtract means no borrow (A >= B)
//   busy                    high whenever the FSM is not IDLE
module alu_seq_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic       sub0,
  input  logic       sub1,
  output logic       ack0,
  output logic       ack1,
  output logic [1:0] sl_a,
  output logic [1:0] sl_b,
  output logic       sl_ci,
  input  logic [1:0] sl_sum,
  input  logic       sl_co,
  output logic       rsp_v,
  output logic       rsp_id,
  output logic [7:0] rsp_r,
  output logic       rsp_co,
  input  logic       rsp_rdy,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [1:0] digit;
  logic       carry;
  logic [7:0] result;
  logic [7:0] op_a, op_b;
  logic       op_sub;
  logic       op_id;
  logic       prio;     // requester favoured on a tie
  logic       gnt_v;
  logic       gnt_id;
  logic [2:0] bit_lo;

  assign gnt_v  = req0 | req1;
  // A tie goes to the pointer; otherwise the sole requester wins.
  assign gnt_id = (req0 & req1) ? prio : req1;
  assign bit_lo = {digit, 1'b0};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_v) state_nxt = RUN;
      RUN:     if (digit == 2'd3) state_nxt = DONE;
      DONE:    if (rsp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    ack0   = 1'b0;
    ack1   = 1'b0;
    sl_a   = 2'b00;
    sl_b   = 2'b00;
    sl_ci  = 1'b0;
    rsp_v  = 1'b0;
    rsp_id = 1'b0;
    rsp_r  = 8'h00;
    rsp_co = 1'b0;
    busy   = (state != IDLE);
    case (state)
      IDLE: begin
        // ack is combinational from the requests, so it is gated by rst_n to
        // stay low while reset holds the FSM in IDLE.
        ack0 = rst_n & gnt_v & ~gnt_id;
        ack1 = rst_n & gnt_v & gnt_id;
      end
      RUN: begin
        sl_a  = op_a[bit_lo +: 2];
        sl_b  = op_b[bit_lo +: 2] ^ {2{op_sub}};
        sl_ci = (digit == 2'd0) ? op_sub : carry;
      end
      DONE: begin
        rsp_v  = 1'b1;
        rsp_id = op_id;
        rsp_r  = result;
        rsp_co = carry;
      end
      default: ;
    endcase
  end

  // operand capture, digit counter and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit  <= 2'd0;
      carry  <= 1'b0;
      result <= 8'h00;
      op_a   <= 8'h00;
      op_b   <= 8'h00;
      op_sub <= 1'b0;
      op_id  <= 1'b0;
      prio   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_v) begin
            op_a   <= gnt_id ? a1 : a0;
            op_b   <= gnt_id ? b1 : b0;
            op_sub <= gnt_id ? sub1 : sub0;
            op_id  <= gnt_id;
            prio   <= ~gnt_id;
            digit  <= 2'd0;
          end
        end
        RUN: begin
          result[bit_lo +: 2] <= sl_sum;
          carry               <= sl_co;
          digit               <= digit + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_arb.sv
// Self-checking bench for alu_seq_arb. Supplies the 2-bit adder slice as a
// plain behavioural adder and checks every operation against arithmetic
// computed directly from the operands plus a round-robin tie model.
module tb_alu_seq_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] a0, a1, b0, b1;
  logic       sub0, sub1;
  logic       ack0, ack1;
  logic [1:0] sl_a, sl_b;
  logic       sl_ci;
  logic [1:0] sl_sum;
  logic       sl_co;
  logic       rsp_v, rsp_id;
  logic [7:0] rsp_r;
  logic       rsp_co;
  logic       rsp_rdy;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ack = 0;
  int ack_gap  = 0;
  int exp_prio = 0;

  alu_seq_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .sub0(sub0), .sub1(sub1),
    .ack0(ack0), .ack1(ack1),
    .sl_a(sl_a), .sl_b(sl_b), .sl_ci(sl_ci),
    .sl_sum(sl_sum), .sl_co(sl_co),
    .rsp_v(rsp_v), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_co(rsp_co),
    .rsp_rdy(rsp_rdy), .busy(busy)
  );

  // external 2-bit slice
  logic [2:0] slice_full;
  assign slice_full = {1'b0, sl_a} + {1'b0, sl_b} + {2'b00, sl_ci};
  assign sl_sum = slice_full[1:0];
  assign sl_co  = slice_full[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One full transaction: drive requests in IDLE, follow four RUN cycles,
  // hold the response for 'hold' cycles, then accept it.
  task automatic do_op(input logic r0, input logic r1,
                       input logic [7:0] x0, input logic [7:0] y0, input logic s0,
                       input logic [7:0] x1, input logic [7:0] y1, input logic s1,
                       input int hold);
    int g, opa, opb, ops, exp_r, exp_co;
    req0 = r0; req1 = r1;
    a0 = x0; b0 = y0; sub0 = s0;
    a1 = x1; b1 = y1; sub1 = s1;
    rsp_rdy = 1'b0;
    g   = (r0 && r1) ? exp_prio : (r1 ? 1 : 0);
    opa = (g == 1) ? int'(x1) : int'(x0);
    opb = (g == 1) ? int'(y1) : int'(y0);
    ops = (g == 1) ? int'(s1) : int'(s0);
    if (ops != 0) begin
      exp_r  = (opa - opb + 256) % 256;
      exp_co = (opa >= opb) ? 1 : 0;
    end else begin
      exp_r  = (opa + opb) % 256;
      exp_co = (opa + opb > 255) ? 1 : 0;
    end
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("ack0_grant", ack0, (g == 0) ? 1 : 0);
    chk("ack1_grant", ack1, (g == 1) ? 1 : 0);
    chk("slice_idle", {sl_a, sl_b, sl_ci}, 0);
    ack_gap  = cyc - last_ack;
    last_ack = cyc;
    exp_prio = 1 - g;
    @(posedge clk); #1;
    // operands and requests after the ack must not matter
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    sub0 = 1'($urandom); sub1 = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rsp_v_run", rsp_v, 0);
      chk("ack_run", {ack0, ack1}, 0);
      chk("busy_run", busy, 1);
      chk("sl_a", sl_a, (opa >> (2 * k)) & 3);
      chk("sl_b", sl_b, ((opb >> (2 * k)) & 3) ^ ((ops != 0) ? 3 : 0));
      if (k == 0) chk("sl_ci0", sl_ci, ops);
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      rsp_rdy = (h == hold);
      @(negedge clk);
      chk("rsp_v", rsp_v, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_r", rsp_r, exp_r);
      chk("rsp_co", rsp_co, exp_co);
      chk("ack_done", {ack0, ack1}, 0);
      chk("slice_done", {sl_a, sl_b, sl_ci}, 0);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    sub0 = 1'b0; sub1 = 1'b0; rsp_rdy = 1'b0;
    @(negedge clk);
    chk("rst_ack", {ack0, ack1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp_v, rsp_id, rsp_co, rsp_r}, 0);
    chk("rst_slice", {sl_a, sl_b, sl_ci}, 0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    exp_prio = 0;
    @(posedge clk); #1;

    // directed operations
    do_op(1, 0, 8'h5A, 8'h3C, 0, 8'h00, 8'h00, 0, 0);
    do_op(0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h01, 1, 0);
    do_op(0, 1, 8'h00, 8'h00, 0, 8'h10, 8'h01, 1, 0);

    // both requesting continuously: alternating grants 6 cycles apart
    for (int i = 0; i < 4; i++) begin
      do_op(1, 1, 8'(8'h11 * i), 8'h22, 1'(i), 8'h80, 8'(8'h07 * i), 0, 0);
      if (i > 0) chk("ack_gap", ack_gap, 6);
    end

    // long hold in DONE
    do_op(1, 0, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 0, 10);

    // reset during the second RUN cycle
    req0 = 1'b1; req1 = 1'b0; a0 = 8'h33; b0 = 8'h44; sub0 = 1'b0;
    @(negedge clk);
    chk("abort_ack", ack0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ack_rst", {ack0, ack1}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp", {rsp_v, rsp_id, rsp_co, rsp_r}, 0);
    chk("abort_slice", {sl_a, sl_b, sl_ci}, 0);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst_n = 1'b1;
    exp_prio = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_v, 0);
      @(posedge clk); #1;
    end
    do_op(0, 1, 8'h00, 8'h00, 0, 8'hC8, 8'h64, 1, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rr;
      rr = 2'($urandom_range(1, 3));
      do_op(rr[0], rr[1],
            8'($urandom), 8'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom),
            $urandom_range(0, 3));
    end

    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("final_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
